// File: rtl/ptr_sync_gray.sv
// ptr_sync_gray
// Multi-stage synchronizer that brings a Gray-coded FIFO pointer from the
// opposite clock domain into the wclk domain.
// It also provides:
//   - a registered binary copy of the synchronized pointer,
//   - the per-cycle advance (delta) and a strobe when it moves,
//   - a post-reset warm-up guard that keeps delta/strobe/error quiet until
//     the chain holds real samples,
//   - an optional illegal-Gray-transition detector, compiled in only when the
//     macro PTR_SYNC_GRAY_CHECK_EN is defined (otherwise gray_err is tied 0).
// The sync stages carry no logic between them, so a single-bit Gray change
// that resolves late still shows up as exactly one new value, never an
// intermediate one.

module ptr_sync_gray #(
   parameter int ADDRESS_SIZE = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                    wclk,
   input  logic                    wrst_n,
   input  logic [ADDRESS_SIZE:0]   read_ptr,
   input  logic                    err_clr,
   output logic [ADDRESS_SIZE:0]   wq_read_ptr_gray,
   output logic [ADDRESS_SIZE:0]   wq_read_ptr_bin,
   output logic [ADDRESS_SIZE:0]   ptr_delta,
   output logic                    ptr_advanced,
   output logic                    gray_err
);

   localparam int PW = ADDRESS_SIZE + 1;
   localparam int CW = $clog2(SYNC_STAGES + 1);

   // Fewer than two stages is not a synchronizer; more than four only adds
   // latency, so both are rejected at elaboration.
   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
         $error("ptr_sync_gray: SYNC_STAGES must be in the range 2..4");
      end
   endgenerate

   typedef enum logic {
      WARM = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   warm_cnt;
   logic [CW-1:0]   warm_cnt_next;
   logic            run_en;

   logic [PW-1:0]   stage [SYNC_STAGES];
   logic [PW-1:0]   bin_next;
   logic [PW-1:0]   delta_next;

   // Plain flop chain; stage 0 is the only flop that sees the asynchronous input.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= read_ptr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign wq_read_ptr_gray = stage[SYNC_STAGES-1];

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin_next         = '0;
      bin_next[PW-1]   = wq_read_ptr_gray[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         bin_next[i] = bin_next[i+1] ^ wq_read_ptr_gray[i];
      end
   end

   // Unsigned subtraction at pointer width gives the wrap-around distance.
   assign delta_next = bin_next - wq_read_ptr_bin;

   // Warm-up state register and counter.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state    <= WARM;
         warm_cnt <= '0;
      end else begin
         state    <= state_next;
         warm_cnt <= warm_cnt_next;
      end
   end

   // Stay in WARM until the counter has seen the chain fill, then run forever.
   always_comb begin
      state_next    = state;
      warm_cnt_next = warm_cnt;
      run_en        = 1'b0;
      case (state)
         WARM: begin
            if (warm_cnt == CW'(SYNC_STAGES)) begin
               state_next = RUN;
            end else begin
               warm_cnt_next = warm_cnt + 1'b1;
            end
         end
         RUN: begin
            run_en = 1'b1;
         end
         default: begin
            state_next = WARM;
         end
      endcase
   end

   // Binary copy always tracks the chain; delta and strobe only update in RUN.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wq_read_ptr_bin <= '0;
         ptr_delta       <= '0;
         ptr_advanced    <= 1'b0;
      end else begin
         wq_read_ptr_bin <= bin_next;
         if (run_en) begin
            ptr_delta    <= delta_next;
            ptr_advanced <= |delta_next;
         end
      end
   end

`ifdef PTR_SYNC_GRAY_CHECK_EN
   logic [PW-1:0] prev_gray;
   logic [PW-1:0] gray_diff;
   logic          multi_bit;

   assign gray_diff = wq_read_ptr_gray ^ prev_gray;
   // x & (x-1) is non-zero exactly when more than one bit of x is set.
   assign multi_bit = |(gray_diff & (gray_diff - 1'b1));

   // Sticky error flag; a new detection wins over a simultaneous clear.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         prev_gray <= '0;
         gray_err  <= 1'b0;
      end else begin
         prev_gray <= wq_read_ptr_gray;
         if (run_en) begin
            gray_err <= multi_bit | (gray_err & ~err_clr);
         end
      end
   end
`else
   logic unused_err_clr;

   assign gray_err       = 1'b0;
   assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_ptr_sync_gray.sv
// tb_ptr_sync_gray
// Directed bench for ptr_sync_gray. The main instance uses SYNC_STAGES=2,
// a second instance uses SYNC_STAGES=3 for the latency scenario. Expected
// gray_err values follow PTR_SYNC_GRAY_CHECK_EN.

module tb_ptr_sync_gray;

   localparam int AW = 4;

   logic          wclk;
   logic          wrst_n;
   logic [AW:0]   read_ptr;
   logic [AW:0]   read_ptr3;
   logic          err_clr;

   logic [AW:0]   gray;
   logic [AW:0]   bin;
   logic [AW:0]   delta;
   logic          adv;
   logic          err;

   logic [AW:0]   gray3;
   logic [AW:0]   bin3;
   logic [AW:0]   delta3;
   logic          adv3;
   logic          err3;

   int            errors;
   int            checks;
   logic          exp_err;

   ptr_sync_gray #(.ADDRESS_SIZE(AW), .SYNC_STAGES(2)) dut (
      .wclk             (wclk),
      .wrst_n           (wrst_n),
      .read_ptr         (read_ptr),
      .err_clr          (err_clr),
      .wq_read_ptr_gray (gray),
      .wq_read_ptr_bin  (bin),
      .ptr_delta        (delta),
      .ptr_advanced     (adv),
      .gray_err         (err)
   );

   ptr_sync_gray #(.ADDRESS_SIZE(AW), .SYNC_STAGES(3)) dut3 (
      .wclk             (wclk),
      .wrst_n           (wrst_n),
      .read_ptr         (read_ptr3),
      .err_clr          (1'b0),
      .wq_read_ptr_gray (gray3),
      .wq_read_ptr_bin  (bin3),
      .ptr_delta        (delta3),
      .ptr_advanced     (adv3),
      .gray_err         (err3)
   );

   // Free-running destination clock.
   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [AW:0] ptr, input logic clr);
      read_ptr = ptr;
      err_clr  = clr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkMain(input string tag, input logic [AW:0] g, input logic [AW:0] b,
                            input logic [AW:0] d, input logic a, input logic e);
      checkOutput({tag, ".gray"},  32'(gray),  32'(g));
      checkOutput({tag, ".bin"},   32'(bin),   32'(b));
      checkOutput({tag, ".delta"}, 32'(delta), 32'(d));
      checkOutput({tag, ".adv"},   32'(adv),   32'(a));
      checkOutput({tag, ".err"},   32'(err),   32'(e));
   endtask

   task automatic checkLat(input string tag, input logic [AW:0] g, input logic [AW:0] b,
                           input logic [AW:0] d, input logic a);
      checkOutput({tag, ".gray3"},  32'(gray3),  32'(g));
      checkOutput({tag, ".bin3"},   32'(bin3),   32'(b));
      checkOutput({tag, ".delta3"}, 32'(delta3), 32'(d));
      checkOutput({tag, ".adv3"},   32'(adv3),   32'(a));
      checkOutput({tag, ".err3"},   32'(err3),   32'(0));
   endtask

   // Directed sequence: reset/warm-up, latency, Gray error, wrap, mid-run reset.
   initial begin
      errors    = 0;
      checks    = 0;
`ifdef PTR_SYNC_GRAY_CHECK_EN
      exp_err   = 1'b1;
`else
      exp_err   = 1'b0;
`endif
      wrst_n    = 1'b0;
      read_ptr  = '0;
      read_ptr3 = '0;
      err_clr   = 1'b0;

      repeat (2) tick();
      checkMain("reset", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      checkLat("reset", 5'b00000, 5'b00000, 5'b00000, 1'b0);

      wrst_n = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         checkMain($sformatf("warm%0d", n), 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      end
      repeat (3) tick();
      checkMain("steady", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      checkLat("steady", 5'b00000, 5'b00000, 5'b00000, 1'b0);

      // SYNC_STAGES=3 latency: capture edge, then gray two edges later, bin three.
      read_ptr3 = 5'b00001;
      tick();
      tick();
      checkLat("lat_k1", 5'b00000, 5'b00000, 5'b00000, 1'b0);
      tick();
      checkLat("lat_k2", 5'b00001, 5'b00000, 5'b00000, 1'b0);
      tick();
      checkLat("lat_k3", 5'b00001, 5'b00001, 5'b00001, 1'b1);
      tick();
      checkLat("lat_k4", 5'b00001, 5'b00001, 5'b00000, 1'b0);

      // Two-bit jump 00000 -> 00011 (binary 2).
      applyStimulus(5'b00011, 1'b0);
      tick();
      tick();
      checkMain("jump_g", 5'b00011, 5'b00000, 5'b00000, 1'b0, 1'b0);
      tick();
      checkMain("jump_b", 5'b00011, 5'b00010, 5'b00010, 1'b1, exp_err);
      tick();
      checkMain("jump_hold1", 5'b00011, 5'b00010, 5'b00000, 1'b0, exp_err);
      tick();
      checkMain("jump_hold2", 5'b00011, 5'b00010, 5'b00000, 1'b0, exp_err);

      // Fresh two-bit jump back to 00000 with err_clr on the detection edge.
      applyStimulus(5'b00000, 1'b0);
      tick();
      tick();
      err_clr = 1'b1;
      tick();
      checkMain("clr_vs_set", 5'b00000, 5'b00000, 5'b11110, 1'b1, exp_err);
      tick();
      err_clr = 1'b0;
      checkMain("clr_only", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      tick();
      checkMain("clr_stay", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);

      // Move to binary 29 (Gray 10011), then clear the error it raises.
      applyStimulus(5'b10011, 1'b0);
      repeat (3) tick();
      checkMain("to29", 5'b10011, 5'b11101, 5'b11101, 1'b1, exp_err);
      repeat (2) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkMain("to29_clr", 5'b10011, 5'b11101, 5'b00000, 1'b0, 1'b0);

      // Wrap walk 30 -> 31 -> 0 in Gray, one step per cycle.
      applyStimulus(5'b10001, 1'b0);
      tick();
      read_ptr = 5'b10000;
      tick();
      read_ptr = 5'b00000;
      tick();
      checkMain("wrap30", 5'b10000, 5'b11110, 5'b00001, 1'b1, 1'b0);
      tick();
      checkMain("wrap31", 5'b00000, 5'b11111, 5'b00001, 1'b1, 1'b0);
      tick();
      checkMain("wrap0", 5'b00000, 5'b00000, 5'b00001, 1'b1, 1'b0);
      tick();
      checkMain("wrap_idle", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);

      // Bring bin to 01010 (Gray 01111), then reset mid-cycle.
      applyStimulus(5'b01111, 1'b0);
      repeat (3) tick();
      checkMain("to10", 5'b01111, 5'b01010, 5'b01010, 1'b1, exp_err);
      tick();
      #2;
      wrst_n = 1'b0;
      #1;
      checkMain("midrst_now", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      checkLat("midrst_now", 5'b00000, 5'b00000, 5'b00000, 1'b0);
      tick();
      tick();
      checkMain("midrst_hold", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      wrst_n = 1'b1;

      // Warm-up restarts: bin tracks the chain while delta/strobe/err stay quiet.
      tick();
      checkMain("rewarm1", 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0);
      tick();
      checkMain("rewarm2", 5'b01111, 5'b00000, 5'b00000, 1'b0, 1'b0);
      tick();
      checkMain("rewarm3", 5'b01111, 5'b01010, 5'b00000, 1'b0, 1'b0);
      tick();
      checkMain("rewarm4", 5'b01111, 5'b01010, 5'b00000, 1'b0, 1'b0);

      // Single-bit step to binary 11 (Gray 01110) once running again.
      applyStimulus(5'b01110, 1'b0);
      repeat (3) tick();
      checkMain("rerun", 5'b01110, 5'b01011, 5'b00001, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
